// File: rtl/shift_packer.sv
// Word-to-beat packer: gathers NUM_WORDS words of DATA_W bits into one wide beat
// behind a valid/ready output register, with flush of partial beats and sticky drop detection.
module shift_packer #(
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 8,
    parameter int ORDER     = 0,
    localparam int CW       = $clog2(NUM_WORDS + 1)
) (
    input  logic                          clk_data,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             data_i,
    input  logic                          wr_en_i,
    output logic                          wr_ready_o,
    input  logic                          flush_i,
    output logic [DATA_W*NUM_WORDS-1:0]   data_o,
    output logic                          data_valid_o,
    input  logic                          data_ready_i,
    output logic [CW-1:0]                 word_cnt_o,
    output logic                          drop_err_o
);

    localparam int            BW        = DATA_W * NUM_WORDS;
    localparam logic [CW-1:0] LAST_CNT  = CW'(NUM_WORDS - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(NUM_WORDS);

    logic [BW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] out_q, out_d;
    logic          out_valid_q, out_valid_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic          flush_pend_q, flush_pend_d;
    logic          err_q, err_d;

    logic          slot_free;
    logic          wr_ready;
    logic          accept;
    logic          full_beat;
    logic          flush_req;
    logic [BW-1:0] acc_ins;
    logic [BW-1:0] acc_next;
    logic [CW-1:0] eff_cnt;

    assign slot_free = !out_valid_q || data_ready_i;
    assign wr_ready  = !rst && !flush_pend_q && ((cnt_q != LAST_CNT) || slot_free);
    assign accept    = wr_en_i && wr_ready;
    assign full_beat = accept && (cnt_q == LAST_CNT);
    assign flush_req = flush_i || flush_pend_q;
    assign acc_next  = accept ? acc_ins : acc_q;
    assign eff_cnt   = cnt_q + CW'(accept);

    // The accumulator is always kept in final packed form, so a partial beat needs no realignment.
    always_comb begin
        acc_ins = acc_q;
        if (ORDER == 0) begin
            acc_ins = {acc_q[BW-DATA_W-1:0], data_i};
        end else begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (cnt_q == CW'(i)) begin
                    acc_ins[i*DATA_W +: DATA_W] = data_i;
                end
            end
        end
    end

    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        out_cnt_d    = out_cnt_q;
        flush_pend_d = flush_pend_q;
        err_d        = err_q;

        if (out_valid_q && data_ready_i) begin
            out_valid_d = 1'b0;
            out_cnt_d   = '0;
        end

        // A completing write wins over a flush; the flush then finds nothing left to emit.
        if (full_beat) begin
            out_d        = acc_ins;
            out_valid_d  = 1'b1;
            out_cnt_d    = FULL_CNT;
            acc_d        = '0;
            cnt_d        = '0;
            flush_pend_d = 1'b0;
        end else begin
            acc_d = acc_next;
            cnt_d = eff_cnt;
            if (flush_req) begin
                if (eff_cnt == '0) begin
                    flush_pend_d = 1'b0;
                end else if (slot_free) begin
                    out_d        = acc_next;
                    out_valid_d  = 1'b1;
                    out_cnt_d    = eff_cnt;
                    acc_d        = '0;
                    cnt_d        = '0;
                    flush_pend_d = 1'b0;
                end else begin
                    flush_pend_d = 1'b1;
                end
            end
        end

        if (wr_en_i && !wr_ready) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_data) begin
        if (rst) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            out_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            out_cnt_q    <= out_cnt_d;
            flush_pend_q <= flush_pend_d;
            err_q        <= err_d;
        end
    end

    // Outputs are forced low while reset is held, even before the first reset edge.
    assign wr_ready_o   = wr_ready;
    assign data_o       = rst ? '0 : out_q;
    assign data_valid_o = !rst && out_valid_q;
    assign word_cnt_o   = rst ? '0 : out_cnt_q;
    assign drop_err_o   = !rst && err_q;

    cnt_in_range: assert property (@(posedge clk_data) disable iff (rst) cnt_q < FULL_CNT);

endmodule

// File: tb/tb_shift_packer.sv
// Directed bench for shift_packer: a table of streaming vectors plus hand-written
// sequences for flush, backpressure, drop, same-cycle write+flush and mid-beat reset.
module tb_shift_packer;

    logic          clk_data;
    logic          rst;
    logic [31:0]   dataIn;
    logic          wrEn;
    logic          flush;
    logic          dataReady;

    logic [255:0]  data0, data1;
    logic          valid0, valid1;
    logic [3:0]    cnt0, cnt1;
    logic          wrReady0, wrReady1;
    logic          err0, err1;

    int checks;
    int errors;

    typedef struct {
        logic         wr;
        logic [31:0]  d;
        logic         fl;
        logic         rdy;
        logic         expWrReady;
        logic         expValid;
        logic [3:0]   expCnt;
        logic [255:0] expData0;
        logic [255:0] expData1;
    } vec_t;

    vec_t vecs[24];
    logic [255:0] beatOrd0[3];
    logic [255:0] beatOrd1[3];

    shift_packer #(.DATA_W(32), .NUM_WORDS(8), .ORDER(0)) dut0 (
        .clk_data(clk_data), .rst(rst), .data_i(dataIn), .wr_en_i(wrEn),
        .wr_ready_o(wrReady0), .flush_i(flush), .data_o(data0),
        .data_valid_o(valid0), .data_ready_i(dataReady),
        .word_cnt_o(cnt0), .drop_err_o(err0)
    );

    shift_packer #(.DATA_W(32), .NUM_WORDS(8), .ORDER(1)) dut1 (
        .clk_data(clk_data), .rst(rst), .data_i(dataIn), .wr_en_i(wrEn),
        .wr_ready_o(wrReady1), .flush_i(flush), .data_o(data1),
        .data_valid_o(valid1), .data_ready_i(dataReady),
        .word_cnt_o(cnt1), .drop_err_o(err1)
    );

    initial clk_data = 1'b0;
    always #5 clk_data = ~clk_data;

    // Inputs change 1-2 time units after the rising edge, well away from the next one.
    task automatic applyStimulus(input logic wr, input logic [31:0] d, input logic fl,
                                 input logic rdy, input logic r);
        wrEn      = wr;
        dataIn    = d;
        flush     = fl;
        dataReady = rdy;
        rst       = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_data);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic doReset(input logic rdy);
        applyStimulus(1'b0, 32'h0, 1'b0, rdy, 1'b1);
        checkOutput("rst wr_ready", 256'(wrReady0), 256'(1'b0));
        checkOutput("rst valid", 256'(valid0), 256'(1'b0));
        checkOutput("rst data", data0, 256'h0);
        checkOutput("rst cnt", 256'(cnt0), 256'(4'd0));
        checkOutput("rst err", 256'(err0), 256'(1'b0));
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, rdy, 1'b0);
    endtask

    task automatic writeWord(input logic [31:0] d, input logic rdy);
        applyStimulus(1'b1, d, 1'b0, rdy, 1'b0);
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;

        beatOrd0[0] = 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008;
        beatOrd0[1] = 256'h00000009_0000000a_0000000b_0000000c_0000000d_0000000e_0000000f_00000010;
        beatOrd0[2] = 256'h00000011_00000012_00000013_00000014_00000015_00000016_00000017_00000018;
        beatOrd1[0] = 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001;
        beatOrd1[1] = 256'h00000010_0000000f_0000000e_0000000d_0000000c_0000000b_0000000a_00000009;
        beatOrd1[2] = 256'h00000018_00000017_00000016_00000015_00000014_00000013_00000012_00000011;

        for (int i = 0; i < 24; i++) begin
            vecs[i].wr         = 1'b1;
            vecs[i].d          = 32'(i + 1);
            vecs[i].fl         = 1'b0;
            vecs[i].rdy        = 1'b1;
            vecs[i].expWrReady = 1'b1;
            vecs[i].expValid   = ((i % 8) == 7);
            vecs[i].expCnt     = ((i % 8) == 7) ? 4'd8 : 4'd0;
            vecs[i].expData0   = beatOrd0[i / 8];
            vecs[i].expData1   = beatOrd1[i / 8];
        end

        // Streaming: three back-to-back beats with the consumer always ready.
        doReset(1'b1);
        for (int i = 0; i < 24; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].d, vecs[i].fl, vecs[i].rdy, 1'b0);
            checkOutput("t1 wr_ready", 256'(wrReady0), 256'(vecs[i].expWrReady));
            tick();
            checkOutput("t1 valid0", 256'(valid0), 256'(vecs[i].expValid));
            checkOutput("t1 valid1", 256'(valid1), 256'(vecs[i].expValid));
            checkOutput("t1 cnt0", 256'(cnt0), 256'(vecs[i].expCnt));
            checkOutput("t1 cnt1", 256'(cnt1), 256'(vecs[i].expCnt));
            if (vecs[i].expValid) begin
                checkOutput("t1 data0", data0, vecs[i].expData0);
                checkOutput("t1 data1", data1, vecs[i].expData1);
            end
        end

        // Partial beat flush in both word orders, then an empty flush.
        doReset(1'b1);
        writeWord(32'hA, 1'b1);
        writeWord(32'hB, 1'b1);
        writeWord(32'hC, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("t2 valid1", 256'(valid1), 256'(1'b1));
        checkOutput("t2 data1", data1, 256'h0000000c_0000000b_0000000a);
        checkOutput("t2 cnt1", 256'(cnt1), 256'(4'd3));
        checkOutput("t2 data0", data0, 256'h0000000a_0000000b_0000000c);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("t2 drained", 256'(valid1), 256'(1'b0));
        checkOutput("t2 drained cnt", 256'(cnt1), 256'(4'd0));
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("t2 empty flush", 256'(valid1), 256'(1'b0));
        tick();
        checkOutput("t2 empty flush late", 256'(valid0), 256'(1'b0));

        // Backpressure: held beat, stall at cnt=7, dropped write, release.
        doReset(1'b0);
        for (int i = 1; i <= 8; i++) writeWord(32'(i), 1'b0);
        checkOutput("t3 held valid", 256'(valid0), 256'(1'b1));
        for (int i = 9; i <= 15; i++) writeWord(32'(i), 1'b0);
        checkOutput("t3 held data", data0, beatOrd0[0]);
        checkOutput("t3 held cnt", 256'(cnt0), 256'(4'd8));
        applyStimulus(1'b1, 32'h99, 1'b0, 1'b0, 1'b0);
        checkOutput("t3 stalled wr_ready", 256'(wrReady0), 256'(1'b0));
        tick();
        checkOutput("t3 drop_err", 256'(err0), 256'(1'b1));
        checkOutput("t3 still held", data0, beatOrd0[0]);
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b1, 1'b0);
        checkOutput("t3 release wr_ready", 256'(wrReady0), 256'(1'b1));
        tick();
        checkOutput("t3 new valid", 256'(valid0), 256'(1'b1));
        checkOutput("t3 new data", data0, beatOrd0[1]);
        checkOutput("t3 err sticky", 256'(err0), 256'(1'b1));
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("t3 drained", 256'(valid0), 256'(1'b0));

        // Flush against a full output slot waits as a pending flush.
        doReset(1'b0);
        checkOutput("t4 err cleared", 256'(err0), 256'(1'b0));
        for (int i = 1; i <= 8; i++) writeWord(32'(i), 1'b0);
        writeWord(32'h21, 1'b0);
        writeWord(32'h22, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            checkOutput("t4 pend wr_ready", 256'(wrReady0), 256'(1'b0));
            checkOutput("t4 pend held", data0, beatOrd0[0]);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("t4 pend wr_ready at release", 256'(wrReady0), 256'(1'b0));
        tick();
        checkOutput("t4 partial valid", 256'(valid0), 256'(1'b1));
        checkOutput("t4 partial cnt", 256'(cnt0), 256'(4'd2));
        checkOutput("t4 partial data", data0, 256'h00000021_00000022);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("t4 wr_ready back", 256'(wrReady0), 256'(1'b1));
        tick();
        checkOutput("t4 drained", 256'(valid0), 256'(1'b0));

        // Completing write and flush in the same cycle yield exactly one full beat.
        doReset(1'b1);
        for (int i = 1; i <= 7; i++) writeWord(32'(i), 1'b1);
        applyStimulus(1'b1, 32'h8, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("t5 valid", 256'(valid0), 256'(1'b1));
        checkOutput("t5 cnt", 256'(cnt0), 256'(4'd8));
        checkOutput("t5 data", data0, beatOrd0[0]);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("t5 no extra beat", 256'(valid0), 256'(1'b0));
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("t5 cnt was zero", 256'(valid0), 256'(1'b0));

        // Reset with a partial beat and a held beat, then a clean beat.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) writeWord(32'(i), 1'b0);
        for (int i = 1; i <= 5; i++) writeWord(32'h30 + 32'(i), 1'b0);
        checkOutput("t6 held before rst", 256'(valid0), 256'(1'b1));
        doReset(1'b0);
        checkOutput("t6 after rst valid", 256'(valid0), 256'(1'b0));
        checkOutput("t6 after rst data", data0, 256'h0);
        for (int i = 1; i <= 8; i++) writeWord(32'h40 + 32'(i), 1'b1);
        checkOutput("t6 clean valid", 256'(valid0), 256'(1'b1));
        checkOutput("t6 clean cnt", 256'(cnt0), 256'(4'd8));
        checkOutput("t6 clean data", data0,
                    256'h00000041_00000042_00000043_00000044_00000045_00000046_00000047_00000048);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_packer.md
Name: shift_packer

Overview:
- Parametrised word-to-beat packer; successor of the fixed 32-to-256 shift buffer on the clk_data domain.
- Collects NUM_WORDS input words of DATA_W bits into one wide beat and presents it on a valid/ready output register.
- Adds output backpressure, selectable word order, flush of partial beats with a word count, and sticky drop detection.
- Sits between the serial data ingest and the wide MulAdd operand path.

Parameters:
- DATA_W, 32: input word width in bits, >=1.
- NUM_WORDS, 8: words per output beat, >=2.
- ORDER, 0: 0 = newest word in LSB (first word ends at MSB); 1 = first word in LSB (word i at bits [(i+1)*DATA_W-1 : i*DATA_W]).
- CW (localparam), $clog2(NUM_WORDS+1): width of the word counter.

Ports:
- clk_data  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- data_i  in  DATA_W  input word.
- wr_en_i  in  1  write request; accepted when wr_en_i && wr_ready_o.
- wr_ready_o  out  1  packer can accept a word this cycle.
- flush_i  in  1  one-cycle pulse: emit the current partial beat.
- data_o  out  DATA_W*NUM_WORDS  output beat.
- data_valid_o  out  1  data_o holds a beat.
- data_ready_i  in  1  consumer accepts the beat when data_valid_o && data_ready_i.
- word_cnt_o  out  CW  valid words in data_o (1..NUM_WORDS); 0 when not valid.
- drop_err_o  out  1  sticky: a write was presented while wr_ready_o=0.

Behaviour:
- State:
  - acc: accumulator of NUM_WORDS words.
  - cnt: words held, 0..NUM_WORDS-1.
  - out_reg, out_valid, out_cnt: output register contents, valid flag and word count.
  - flush_pend, err: pending-flush and sticky-error registers.
- Reset (rst=1 at an edge): acc, cnt, out_reg, out_valid, out_cnt, flush_pend and err all cleared. While rst is high: data_o=0, data_valid_o=0, word_cnt_o=0, drop_err_o=0, wr_ready_o=0. Reset mid-beat discards the partial beat and any held output beat.
- Slot free: slot_free = !out_valid || data_ready_i (combinational from data_ready_i).
- wr_ready_o = !rst && !flush_pend && (cnt != NUM_WORDS-1 || slot_free).
- Accepted write:
  - cnt < NUM_WORDS-1: the word is stored and cnt increments.
  - cnt == NUM_WORDS-1: the full beat (acc plus the new word, packed per ORDER) loads into out_reg; out_valid=1; out_cnt=NUM_WORDS; cnt=0; acc cleared.
- Latency: the last accepted word appears on data_o the next cycle.
- Packing:
  - ORDER=0: each new word shifts acc left by DATA_W and enters at the LSB. A partial beat of k words occupies bits [k*DATA_W-1:0], first word highest; upper bits are 0.
  - ORDER=1: word i goes to slot i. In a partial beat, slots >= k are 0.
- Flush (flush_i pulse, or flush_pend=1):
  - If the effective count is 0, it is a no-op and flush_pend clears. The effective count includes any write accepted in the same cycle.
  - Otherwise, if slot_free: out_reg = packed partial beat, out_cnt = effective count, out_valid=1, cnt=0, flush_pend=0.
  - If the slot is not free, flush_pend=1. While flush_pend=1, wr_ready_o=0; the flush executes in the first cycle slot_free=1.
  - A same-cycle write that completes a full beat takes priority: the full beat is emitted and the flush becomes a no-op (count 0 afterwards).
- Output handshake:
  - data_o, data_valid_o and word_cnt_o are registered and stay stable while data_valid_o && !data_ready_i.
  - On acceptance with no new beat loading, out_valid=0 and out_cnt=0. data_o keeps its last value; it is don't-care when not valid.
  - Accept and load in the same cycle: the new beat replaces the old one with no bubble.
- Sustained throughput: one word per cycle when data_ready_i=1, i.e. one beat every NUM_WORDS cycles.
- Drop: wr_en_i && !wr_ready_o (outside reset) discards the word and sets err (drop_err_o=1) until reset.
- cnt never reaches NUM_WORDS; no wrap-around beyond the increment to 0.

Test Plan:
1. Defaults, ORDER=0, data_ready_i=1, write 0x1..0x8 on 8 consecutive cycles -> one cycle after the 8th write: data_valid_o=1 for 1 cycle, data_o=0x00000001_00000002_..._00000008, word_cnt_o=8. Then 16 more words -> two beats, no stall.
2. ORDER=1, write 0xA,0xB,0xC, pulse flush_i -> next cycle data_o[31:0]=0xA, [63:32]=0xB, [95:64]=0xC, upper 160 bits 0, word_cnt_o=3. Flush with cnt=0 -> no beat.
3. data_ready_i=0, write 16 words -> first beat held stable. wr_ready_o drops with cnt=7 and the second beat incomplete. A write then sets drop_err_o=1 and is lost. Raise data_ready_i -> the 8th word is accepted and the new beat is valid on the next cycle.
4. Output full (data_ready_i=0), cnt=2, flush_i pulse -> flush_pend holds wr_ready_o=0. Ready asserted 5 cycles later -> the partial beat emits with word_cnt_o=2.
5. cnt=7, write plus flush_i in the same cycle -> one full beat with word_cnt_o=8, no extra empty beat, cnt=0.
6. rst asserted for 1 cycle with cnt=5 and a beat held -> all outputs 0. The next 8 writes form a clean beat with no residue from before reset.
